// File: rtl/canny_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : canny_pkg                                                        |
// | Brief   : Shared types and constants for the Canny hysteresis stage.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package canny_pkg;

    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;

    localparam logic [7:0] PIX_STRONG = 8'hFF;
    localparam logic [7:0] PIX_NONE   = 8'h00;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_WEAK   = 2'd1,
        CLS_STRONG = 2'd2
    } pix_cls_e;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } trk_state_e;

    function automatic pix_cls_e classify(input logic [7:0] pix);
        if (pix == PIX_STRONG) begin
            return CLS_STRONG;
        end
        if (pix == PIX_NONE) begin
            return CLS_NONE;
        end
        return CLS_WEAK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : line_buffer                                                      |
// | Brief   : Single-port read-before-write RAM holding one line of classes.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module line_buffer #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 2,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Asynchronous read returns the old word in the same cycle it is overwritten.
    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hysteresis_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hysteresis_tracker                                               |
// | Brief   : Single-pass 3x3 hysteresis resolving weak/strong pixels to edges.|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module hysteresis_tracker
    import canny_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic [7:0] data_out,
    output logic       data_out_valid
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] c_col_one  = COL_W'(1);
    localparam logic [ROW_W-1:0] c_row_one  = ROW_W'(1);

    trk_state_e       state_q, state_d;
    logic [COL_W-1:0] in_col_q, in_col_d;
    logic [ROW_W-1:0] in_row_q, in_row_d;
    logic [COL_W-1:0] out_col_q, out_col_d;
    logic [ROW_W-1:0] out_row_q, out_row_d;
    logic [COL_W-1:0] lb_addr_q, lb_addr_d;

    // Window indexed [row][col]: row 0 oldest line, col 2 newest column.
    logic [2:0][2:0][1:0] win_q, win_d;

    logic [7:0] data_out_q;
    logic       data_out_valid_q;

    logic       w_step;
    logic       w_produce;
    logic       w_edge;
    logic       w_nbr_strong;
    logic [1:0] w_new_cls;
    logic [1:0] w_lb1_rd;
    logic [1:0] w_lb2_rd;

    assign data_in_ready  = (state_q != ST_FLUSH);
    assign w_step         = (state_q == ST_FLUSH) || data_in_valid;
    assign w_new_cls      = (state_q == ST_FLUSH) ? CLS_NONE : classify(data_in);
    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;

    // lb1 holds the previous line, lb2 the line before it.
    line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (2),
        .ADDR_W (COL_W)
    ) u_lb1 (
        .clk     (clk),
        .en_i    (w_step),
        .addr_i  (lb_addr_q),
        .wdata_i (w_new_cls),
        .rdata_o (w_lb1_rd)
    );

    line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (2),
        .ADDR_W (COL_W)
    ) u_lb2 (
        .clk     (clk),
        .en_i    (w_step),
        .addr_i  (lb_addr_q),
        .wdata_i (w_lb1_rd),
        .rdata_o (w_lb2_rd)
    );

    always_comb begin
        win_d = win_q;
        if (w_step) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = w_lb2_rd;
            win_d[1][2] = w_lb1_rd;
            win_d[2][2] = w_new_cls;
        end
    end

    // Decision uses the freshly shifted window so the result lands one cycle after the step.
    always_comb begin
        w_nbr_strong = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!((r == 1) && (c == 1))
                    && !((r == 0) && (out_row_q == '0))
                    && !((r == 2) && (out_row_q == c_row_last))
                    && !((c == 0) && (out_col_q == '0))
                    && !((c == 2) && (out_col_q == c_col_last))
                    && (win_d[r][c] == CLS_STRONG)) begin
                    w_nbr_strong = 1'b1;
                end
            end
        end
        w_edge = (win_d[1][1] == CLS_STRONG)
              || ((win_d[1][1] == CLS_WEAK) && w_nbr_strong);
    end

    always_comb begin
        state_d   = state_q;
        in_col_d  = in_col_q;
        in_row_d  = in_row_q;
        out_col_d = out_col_q;
        out_row_d = out_row_q;
        lb_addr_d = lb_addr_q;
        w_produce = 1'b0;

        if (w_step) begin
            lb_addr_d = (lb_addr_q == c_col_last) ? '0 : lb_addr_q + c_col_one;

            if (state_q != ST_FLUSH) begin
                if (in_col_q == c_col_last) begin
                    in_col_d = '0;
                    in_row_d = (in_row_q == c_row_last) ? '0 : in_row_q + c_row_one;
                end else begin
                    in_col_d = in_col_q + c_col_one;
                end
            end

            if (state_q != ST_FILL) begin
                w_produce = 1'b1;
                if (out_col_q == c_col_last) begin
                    out_col_d = '0;
                    out_row_d = (out_row_q == c_row_last) ? '0 : out_row_q + c_row_one;
                end else begin
                    out_col_d = out_col_q + c_col_one;
                end
            end

            case (state_q)
                ST_FILL: begin
                    if ((in_row_q == c_row_one) && (in_col_q == '0)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if ((in_row_q == c_row_last) && (in_col_q == c_col_last)) begin
                        state_d = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if ((out_row_q == c_row_last) && (out_col_q == c_col_last)) begin
                        state_d   = ST_FILL;
                        in_col_d  = '0;
                        in_row_d  = '0;
                        out_col_d = '0;
                        out_row_d = '0;
                        lb_addr_d = '0;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_FILL;
            in_col_q         <= '0;
            in_row_q         <= '0;
            out_col_q        <= '0;
            out_row_q        <= '0;
            lb_addr_q        <= '0;
            win_q            <= '0;
            data_out_q       <= PIX_NONE;
            data_out_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            in_col_q         <= in_col_d;
            in_row_q         <= in_row_d;
            out_col_q        <= out_col_d;
            out_row_q        <= out_row_d;
            lb_addr_q        <= lb_addr_d;
            win_q            <= win_d;
            data_out_q       <= (w_produce && w_edge) ? PIX_STRONG : PIX_NONE;
            data_out_valid_q <= w_produce;
        end
    end

endmodule
`default_nettype wire
